// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the shared-bus arbiter: FSM state encoding,
// turnaround length and the owner-index width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int TURNAROUND_CYCLES = 1;

  // Index width for n requesters; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from last+1 (mod NUM_REQ) and
// returns the first requesting index, both one-hot and encoded.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int IW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0]      win_idx
);

  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    winner  = '0;
    win_idx = '0;
    // Walk the ring backwards so the nearest requester after 'last' is written last.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_REQ);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Tri-state bus ownership sequencer: one-hot registered grants, a one-cycle
// no-driver turnaround between owners, per-tenure hold limit, round-robin.
module shared_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 2,
  parameter int  DATA_W   = 8,
  parameter int  MAX_HOLD = 4,
  localparam int IW       = owner_w(NUM_REQ),
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] drive_en,
  output logic [IW-1:0]      owner_id,
  output logic               bus_busy,
  output logic               preempt,
  output arb_state_t         state
);

  if (NUM_REQ < 2 || MAX_HOLD < 1 || DATA_W < 1 || TURNAROUND_CYCLES != 1) begin : g_bad_cfg
    $error("shared_bus_arbiter: unsupported parameter set");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] drive_q;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               any_req, owner_done, owner_req, hold_hit, release_now;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .last    (last_q),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  assign any_req     = |req;
  assign owner_done  = done[owner_q];
  assign owner_req   = req[owner_q];
  assign hold_hit    = (hold_q == HW'(MAX_HOLD));
  assign release_now = owner_done | ~owner_req | hold_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      drive_q   <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      drive_q   <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_now) state_d = TURN;
      TURN:    state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      GRANT: begin
        if (release_now) begin
          gnt_d     = '0;
          last_d    = owner_q;
          hold_d    = '0;
          // Only a pure hold-limit cut counts as preemption.
          preempt_d = hold_hit & ~owner_done & owner_req;
        end else begin
          hold_d = hold_hit ? hold_q : hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
        if (any_req) begin
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          hold_d  = HW'(1);
        end
      end
    endcase
  end

  assign gnt      = gnt_q;
  assign drive_en = drive_q;
  assign owner_id = owner_q;
  assign bus_busy = |gnt_q;
  assign preempt  = preempt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: two tri-state requesters on an 8-bit wire,
// a tenure-level reference model feeding an expected queue, and a monitor.
module tb_shared_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NUM_REQ  = 2;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int IW       = owner_w(NUM_REQ);
  localparam int REC_W    = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0] req  = '0;
  logic [NUM_REQ-1:0] done = '0;
  logic [NUM_REQ-1:0] gnt, drive_en;
  logic [IW-1:0]      owner_id;
  logic               bus_busy, preempt;
  arb_state_t         dut_state;

  // ---------------- tri-state bus ----------------
  wire  [DATA_W-1:0] bus;
  logic [DATA_W-1:0] d1  = 8'd3;
  logic [DATA_W-1:0] cap = '0;
  logic [DATA_W-1:0] d0;
  logic              seen_r1 = 1'b0;
  assign d0  = DATA_W'(cap << 1);
  assign bus = drive_en[0] ? d0 : 'z;
  assign bus = drive_en[1] ? d1 : 'z;

  shared_bus_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .drive_en (drive_en),
    .owner_id (owner_id),
    .bus_busy (bus_busy),
    .preempt  (preempt),
    .state    (dut_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input int v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  // ---------------- reference model (tenure level) ----------------
  // Owner -1 means nobody holds the bus; after any release the next edge
  // is the only place a new owner can appear, which is the turnaround gap.
  int m_owner    = -1;
  int m_held     = 0;
  int m_last     = NUM_REQ - 1;
  int m_owner_id = 0;
  bit m_preempt  = 1'b0;
  bit model_live = 1'b0;

  always @(posedge clk) begin
    m_preempt = 1'b0;
    if (!rst_n) begin
      if (m_owner >= 0) exp_q.push_back({1'b0, 7'(m_owner), 8'(m_held)});
      m_owner    = -1;
      m_held     = 0;
      m_last     = NUM_REQ - 1;
      m_owner_id = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (m_owner >= 0) begin
        if (bit_of(int'(done), m_owner) || !bit_of(int'(req), m_owner) || m_held >= MAX_HOLD) begin
          m_preempt = (m_held >= MAX_HOLD) && !bit_of(int'(done), m_owner) && bit_of(int'(req), m_owner);
          exp_q.push_back({m_preempt, 7'(m_owner), 8'(m_held)});
          m_last  = m_owner;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else if (req != '0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (bit_of(int'(req), c) && m_owner < 0) m_owner = c;
        end
        m_held     = 1;
        m_owner_id = m_owner;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [NUM_REQ-1:0] exp_gnt;
  logic [NUM_REQ-1:0] prev_gnt = '0;
  logic [REC_W-1:0]   rec;
  int ten_len   = 0;
  int ten_owner = 0;

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (model_live) begin
      exp_gnt = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
      check("gnt",      int'(gnt),      int'(exp_gnt));
      check("drive_en", int'(drive_en), int'(exp_gnt));
      check("bus_busy", int'(bus_busy), (m_owner >= 0) ? 1 : 0);
      check("owner_id", int'(owner_id), m_owner_id);
      check("preempt",  int'(preempt),  int'(m_preempt));
      if (drive_en[1]) begin
        check("bus_r1", int'(bus), 3);
        cap     = bus;
        seen_r1 = 1'b1;
      end
      if (drive_en[0]) check("bus_r0", int'(bus), seen_r1 ? 6 : 0);

      if (gnt != '0) begin
        if (prev_gnt == '0) begin
          ten_len   = 0;
          ten_owner = onehot_idx(gnt);
        end
        ten_len++;
      end else if (prev_gnt != '0) begin
        check("tenure_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          rec = exp_q.pop_front();
          check("tenure_owner",   ten_owner,     int'(rec[14:8]));
          check("tenure_len",     ten_len,       int'(rec[7:0]));
          check("tenure_preempt", int'(preempt), int'(rec[15]));
        end
      end
      prev_gnt = gnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    req  = '0;
    done = '0;
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    tick();
    tick();
    check("rst_gnt",      int'(gnt),       0);
    check("rst_drive_en", int'(drive_en),  0);
    check("rst_bus_busy", int'(bus_busy),  0);
    check("rst_owner_id", int'(owner_id),  0);
    check("rst_state",    int'(dut_state), int'(IDLE));
    rst_n = 1'b1;
    tick();
    check("first_grant_r0", int'(gnt), 1);
    go_idle();

    // single request with done release
    req = 2'b10;
    tick();
    check("single_gnt",   int'(gnt),      2);
    check("single_owner", int'(owner_id), 1);
    tick();
    done = 2'b10;
    tick();
    done = '0;
    req  = '0;
    check("done_release_gnt",  int'(gnt),      0);
    check("done_release_busy", int'(bus_busy), 0);
    check("done_no_preempt",   int'(preempt),  0);
    tick();
    check("after_turn_idle",  int'(dut_state), int'(IDLE));
    check("owner_id_retains", int'(owner_id),  1);

    // contention: both requesters held
    req = 2'b11;
    repeat (24) tick();
    go_idle();

    // hold limit, lone requester re-granted
    req = 2'b01;
    tick();
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      check("hold_gnt_still", int'(gnt), 1);
    end
    tick();
    check("hold_cut_gnt",     int'(gnt),     0);
    check("hold_cut_preempt", int'(preempt), 1);
    tick();
    check("regrant_r0",       int'(gnt),     1);
    check("preempt_one_shot", int'(preempt), 0);
    repeat (MAX_HOLD - 1) tick();
    req = 2'b11;
    tick();
    check("hold_cut2_preempt", int'(preempt), 1);
    tick();
    check("pending_r1_wins", int'(gnt),      2);
    check("pending_r1_id",   int'(owner_id), 1);
    go_idle();

    // done coincides with the hold limit
    req = 2'b01;
    tick();
    repeat (MAX_HOLD - 1) tick();
    done = 2'b01;
    tick();
    done = '0;
    check("coincide_gnt",     int'(gnt),     0);
    check("coincide_preempt", int'(preempt), 0);
    go_idle();

    // reset in the middle of a tenure
    req = 2'b10;
    tick();
    check("pre_reset_gnt", int'(gnt), 2);
    rst_n = 1'b0;
    tick();
    check("mid_reset_gnt",      int'(gnt),      0);
    check("mid_reset_drive_en", int'(drive_en), 0);
    rst_n = 1'b1;
    req   = 2'b11;
    tick();
    check("post_reset_r0_first", int'(gnt), 1);
    go_idle();

    // randomized traffic with occasional resets and stray done pulses
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, 3));
      done  = ($urandom_range(0, 4) == 0) ? NUM_REQ'($urandom_range(1, 3)) : '0;
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1;
    go_idle();
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
